// File: rtl/store_buffer_pkg.sv
// Shared definitions for the load/store path: access codes, size field,
// legality/alignment check and load-data extension. The data memory and the
// decoder use the same helpers so every unit agrees on what a code means.
package store_buffer_pkg;

  localparam logic [2:0] CTR_B  = 3'b000;
  localparam logic [2:0] CTR_H  = 3'b001;
  localparam logic [2:0] CTR_W  = 3'b010;
  localparam logic [2:0] CTR_BU = 3'b100;
  localparam logic [2:0] CTR_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  // Access size lives in the low two bits; bit 2 only selects zero-extension.
  function automatic size_e ctr_size(input logic [2:0] ctr);
    return size_e'(ctr[1:0]);
  endfunction

  // Legal code and naturally aligned address.
  function automatic logic ctr_legal(input logic [2:0] ctr, input logic [1:0] addr_lo);
    case (ctr)
      CTR_B, CTR_BU: return 1'b1;
      CTR_H, CTR_HU: return ~addr_lo[0];
      CTR_W:         return addr_lo == 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

  // Extend low-aligned data to 32 bits according to the access code.
  function automatic logic [31:0] extend(input logic [2:0] ctr, input logic [31:0] data);
    case (ctr[1:0])
      2'b00:   return ctr[2] ? {24'b0, data[7:0]}   : {{24{data[7]}}, data[7:0]};
      2'b01:   return ctr[2] ? {16'b0, data[15:0]}  : {{16{data[15]}}, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Youngest-match search over the live store-queue entries.
// Ports:
//   head/count      - queue window (oldest slot, number of live entries)
//   ent_addr        - byte address of each slot
//   ent_size        - access size of each slot
//   req_addr/size   - load being looked up
//   hit             - some live entry is in the same 32-bit word
//   exact           - the youngest such entry has identical address and size
//   idx             - slot of that youngest entry
module sb_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic [PW-1:0] head,
  input  logic [CW-1:0] count,
  input  logic [AW-1:0] ent_addr [DEPTH],
  input  logic [1:0]    ent_size [DEPTH],
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_size,
  output logic          hit,
  output logic          exact,
  output logic [PW-1:0] idx
);

  // Walk oldest to youngest so the last hit seen is the youngest.
  always_comb begin : search
    logic [PW-1:0] slot;
    hit   = 1'b0;
    exact = 1'b0;
    idx   = '0;
    slot  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if ((CW'(i) < count) && (ent_addr[slot][AW-1:2] == req_addr[AW-1:2])) begin
        hit   = 1'b1;
        idx   = slot;
        exact = (ent_addr[slot][1:0] == req_addr[1:0]) && (ent_size[slot] == req_size);
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between execute and data memory. Stores are queued in a
// DEPTH-entry FIFO and drained in order whenever the memory port is free;
// loads forward from an exact youngest match or go to memory, and always
// answer one cycle after acceptance.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   req_*                        - core request (valid/ready, we, ctr, addr, wdata)
//   resp_valid, resp_rdata       - load response, one cycle after acceptance
//   misalign_err                 - pulse the cycle after an illegal request
//   sb_empty                     - no stores pending
//   mem_we/ctr/addr/wd, mem_rd   - data memory port (read data one cycle later)
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_ctr,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          misalign_err,
  output logic          sb_empty,
  output logic          mem_we,
  output logic [2:0]    mem_ctr,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] ent_addr  [DEPTH];
  logic [2:0]    ent_ctr   [DEPTH];
  logic [31:0]   ent_wdata [DEPTH];
  logic [1:0]    ent_size  [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          legal;
  logic          is_load;
  logic          is_store;
  logic          load_mem;
  logic          load_fwd;
  logic          load_stall;
  logic          drain;
  logic          store_ok;
  logic          enq;
  logic          hit;
  logic          exact;
  logic [PW-1:0] fwd_idx;

  logic          vld_p1;
  logic          err_p1;
  logic          src_mem_p1;
  logic [31:0]   fwd_data_p1;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_size[i] = ctr_size(ent_ctr[i]);
  end

  sb_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_match (
    .head     (head),
    .count    (count),
    .ent_addr (ent_addr),
    .ent_size (ent_size),
    .req_addr (req_addr),
    .req_size (ctr_size(req_ctr)),
    .hit      (hit),
    .exact    (exact),
    .idx      (fwd_idx)
  );

  // ---- stage p0: request decode, port arbitration ----
  assign legal      = ctr_legal(req_ctr, req_addr[1:0]);
  assign is_load    = req_valid & ~req_we & legal;
  assign is_store   = req_valid &  req_we & legal;
  assign load_mem   = is_load & ~hit;
  assign load_fwd   = is_load &  hit &  exact;
  assign load_stall = is_load &  hit & ~exact;

  // Drain is held off during reset so a mid-drain reset writes nothing.
  assign drain    = ~rst & (count != '0) & ~load_mem;
  assign store_ok = (count < CW'(DEPTH)) | drain;
  assign enq      = is_store & store_ok;

  always_comb begin
    if (!legal)      req_ready = 1'b1;
    else if (req_we) req_ready = store_ok;
    else             req_ready = ~load_stall;
  end

  assign mem_we   = drain;
  assign mem_ctr  = load_mem ? req_ctr  : ent_ctr[head];
  assign mem_addr = load_mem ? req_addr : ent_addr[head];
  assign mem_wd   = ent_wdata[head];
  assign sb_empty = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      vld_p1      <= 1'b0;
      err_p1      <= 1'b0;
      src_mem_p1  <= 1'b0;
      fwd_data_p1 <= '0;
    end else begin
      if (enq)   tail <= tail + PW'(1);
      if (drain) head <= head + PW'(1);
      case ({enq, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      vld_p1     <= load_mem | load_fwd;
      err_p1     <= req_valid & ~legal;
      src_mem_p1 <= load_mem;
      if (load_fwd) fwd_data_p1 <= extend(req_ctr, ent_wdata[fwd_idx]);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[tail]  <= req_addr;
      ent_ctr[tail]   <= req_ctr;
      ent_wdata[tail] <= req_wdata;
    end
  end

  // ---- stage p1: load response ----
  assign resp_valid   = vld_p1;
  assign misalign_err = err_p1;
  assign resp_rdata   = src_mem_p1 ? mem_rd : fwd_data_p1;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_ctr = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign_err;
  logic        sb_empty;
  logic        mem_we;
  logic [2:0]  mem_ctr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd = '0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_ctr      (req_ctr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .misalign_err (misalign_err),
    .sb_empty     (sb_empty),
    .mem_we       (mem_we),
    .mem_ctr      (mem_ctr),
    .mem_addr     (mem_addr),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd)
  );

  int checks = 0;
  int failures = 0;

  // Physical memory (written by the DUT port) and architectural memory
  // (updated in program order when a store is accepted).
  logic [7:0] pmem [logic [31:0]];
  logic [7:0] amem [logic [31:0]];

  logic        cap_we, cap_ready;
  logic [2:0]  cap_ctr;
  logic [31:0] cap_addr, cap_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] c);
    if (c[1:0] == 2'b00) return 1;
    if (c[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] mread(input bit arch, input logic [31:0] a, input logic [2:0] c);
    logic [31:0] raw, mask;
    logic [7:0]  b;
    int n;
    n = nbytes(c);
    raw = '0;
    for (int i = 0; i < n; i++) begin
      if (arch) b = amem.exists(a + 32'(i)) ? amem[a + 32'(i)] : 8'h00;
      else      b = pmem.exists(a + 32'(i)) ? pmem[a + 32'(i)] : 8'h00;
      raw = raw | (32'(b) << (8 * i));
    end
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    if (!c[2] && n < 4 && raw[8*n-1]) raw = raw | ~mask;
    return raw;
  endfunction

  function automatic void mwrite(input bit arch, input logic [31:0] a, input logic [2:0] c,
                                 input logic [31:0] d);
    int n;
    n = nbytes(c);
    for (int i = 0; i < n; i++) begin
      if (arch) amem[a + 32'(i)] = 8'(d >> (8 * i));
      else      pmem[a + 32'(i)] = 8'(d >> (8 * i));
    end
  endfunction

  function automatic bit m_legal(input logic [2:0] c, input logic [31:0] a);
    case (c)
      3'b000, 3'b100: return 1'b1;
      3'b001, 3'b101: return (a % 2) == 0;
      3'b010:         return (a % 4) == 0;
      default:        return 1'b0;
    endcase
  endfunction

  // One clock: drive the request, sample combinational outputs at the
  // falling edge, let the memory act after the rising edge, then leave
  // registered outputs settled for the caller to inspect.
  task automatic drive_cycle(input logic v, input logic we, input logic [2:0] c,
                             input logic [31:0] a, input logic [31:0] d);
    req_valid = v; req_we = we; req_ctr = c; req_addr = a; req_wdata = d;
    @(negedge clk);
    cap_we = mem_we; cap_ready = req_ready; cap_ctr = mem_ctr;
    cap_addr = mem_addr; cap_wd = mem_wd;
    @(posedge clk);
    #1;
    if (cap_we) mwrite(1'b0, cap_addr, cap_ctr, cap_wd);
    else        mem_rd = mread(1'b0, cap_addr, cap_ctr);
    #1;
  endtask

  typedef struct packed {
    logic        v;
    logic        we;
    logic [2:0]  ctr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        mwe;
    logic        rv;
    logic [31:0] rd;
    logic        err;
    logic        empty;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  ctr;
    logic [31:0] wdata;
  } ent_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic v, input logic we, input logic [2:0] c,
                              input logic [31:0] a, input logic [31:0] d, input logic rdy,
                              input logic mwe, input logic rv, input logic [31:0] rd,
                              input logic err, input logic empty);
    vec_t r;
    r.v = v; r.we = we; r.ctr = c; r.addr = a; r.wdata = d; r.ready = rdy;
    r.mwe = mwe; r.rv = rv; r.rd = rd; r.err = err; r.empty = empty;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t        q[$];
    logic        cv, cwe, have_req, lg, memload, stall, drain_m, exp_rdy, acc;
    logic [2:0]  cc;
    logic [31:0] ca, cd, exp_data, off;
    int          stall_cnt;

    //                 v  we ctr     addr          wdata         rdy mwe rv rd            err empty
    tbl[0]  = mk(1, 1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 1, 0, 0, 32'h0,         0, 0);
    tbl[1]  = mk(1, 0, 3'b010, 32'h8000_0010, 32'h0,         1, 1, 1, 32'hDEAD_BEEF, 0, 1);
    tbl[2]  = mk(1, 1, 3'b000, 32'h8000_0020, 32'h0000_00F0, 1, 0, 0, 32'h0,         0, 0);
    tbl[3]  = mk(1, 0, 3'b000, 32'h8000_0020, 32'h0,         1, 1, 1, 32'hFFFF_FFF0, 0, 1);
    tbl[4]  = mk(1, 0, 3'b100, 32'h8000_0020, 32'h0,         1, 0, 1, 32'h0000_00F0, 0, 1);
    tbl[5]  = mk(1, 1, 3'b010, 32'h8000_0030, 32'h1122_3344, 1, 0, 0, 32'h0,         0, 0);
    tbl[6]  = mk(1, 0, 3'b001, 32'h8000_0032, 32'h0,         0, 1, 0, 32'h0,         0, 1);
    tbl[7]  = mk(1, 0, 3'b001, 32'h8000_0032, 32'h0,         1, 0, 1, 32'h0000_1122, 0, 1);
    tbl[8]  = mk(1, 0, 3'b101, 32'h8000_0032, 32'h0,         1, 0, 1, 32'h0000_1122, 0, 1);
    tbl[9]  = mk(1, 1, 3'b010, 32'h8000_0040, 32'h1,         1, 0, 0, 32'h0,         0, 0);
    tbl[10] = mk(1, 1, 3'b010, 32'h8000_0044, 32'h2,         1, 1, 0, 32'h0,         0, 0);
    tbl[11] = mk(1, 1, 3'b010, 32'h8000_0048, 32'h3,         1, 1, 0, 32'h0,         0, 0);
    tbl[12] = mk(1, 1, 3'b010, 32'h8000_004C, 32'h4,         1, 1, 0, 32'h0,         0, 0);
    tbl[13] = mk(1, 1, 3'b010, 32'h8000_0050, 32'h5,         1, 1, 0, 32'h0,         0, 0);
    tbl[14] = mk(1, 1, 3'b010, 32'h8000_0060, 32'hCAFE_F00D, 1, 1, 0, 32'h0,         0, 0);
    tbl[15] = mk(1, 0, 3'b010, 32'h8000_0040, 32'h0,         1, 0, 1, 32'h1,         0, 0);
    tbl[16] = mk(1, 0, 3'b010, 32'h8000_0060, 32'h0,         1, 1, 1, 32'hCAFE_F00D, 0, 1);
    tbl[17] = mk(1, 0, 3'b010, 32'h8000_0050, 32'h0,         1, 0, 1, 32'h5,         0, 1);
    tbl[18] = mk(1, 0, 3'b010, 32'h8000_0002, 32'h0,         1, 0, 0, 32'h0,         1, 1);
    tbl[19] = mk(1, 1, 3'b001, 32'h8000_0001, 32'h1234,      1, 0, 0, 32'h0,         1, 1);
    tbl[20] = mk(1, 1, 3'b011, 32'h8000_0070, 32'h9999,      1, 0, 0, 32'h0,         1, 1);
    tbl[21] = mk(0, 0, 3'b000, 32'h0,         32'h0,         1, 0, 0, 32'h0,         0, 1);
    tbl[22] = mk(1, 1, 3'b001, 32'h8000_0022, 32'h0000_8001, 1, 0, 0, 32'h0,         0, 0);
    tbl[23] = mk(1, 0, 3'b001, 32'h8000_0022, 32'h0,         1, 1, 1, 32'hFFFF_8001, 0, 1);
    tbl[24] = mk(1, 0, 3'b010, 32'h8000_0020, 32'h0,         1, 0, 1, 32'h8001_00F0, 0, 1);

    // Reset state
    rst = 1'b1;
    drive_cycle(0, 0, 3'b000, 32'h0, 32'h0);
    drive_cycle(0, 0, 3'b000, 32'h0, 32'h0);
    chk("reset mem_we", 32'(cap_we), 32'd0);
    chk("reset sb_empty", 32'(sb_empty), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset misalign_err", 32'(misalign_err), 32'd0);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 25; i++) begin
      drive_cycle(tbl[i].v, tbl[i].we, tbl[i].ctr, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].v) chk($sformatf("row%0d req_ready", i), 32'(cap_ready), 32'(tbl[i].ready));
      chk($sformatf("row%0d mem_we", i), 32'(cap_we), 32'(tbl[i].mwe));
      chk($sformatf("row%0d resp_valid", i), 32'(resp_valid), 32'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("row%0d resp_rdata", i), resp_rdata, tbl[i].rd);
      chk($sformatf("row%0d misalign_err", i), 32'(misalign_err), 32'(tbl[i].err));
      chk($sformatf("row%0d sb_empty", i), 32'(sb_empty), 32'(tbl[i].empty));
    end

    // Reset with a queued store: it must be discarded, never written
    drive_cycle(1, 1, 3'b010, 32'h8000_0080, 32'h0000_0055);
    chk("rstq sb_empty before", 32'(sb_empty), 32'd0);
    rst = 1'b1;
    drive_cycle(0, 0, 3'b000, 32'h0, 32'h0);
    chk("rstq mem_we in reset", 32'(cap_we), 32'd0);
    chk("rstq sb_empty after", 32'(sb_empty), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, 3'b000, 32'h0, 32'h0);
      chk($sformatf("rstq idle%0d mem_we", i), 32'(cap_we), 32'd0);
    end
    drive_cycle(1, 0, 3'b010, 32'h8000_0080, 32'h0);
    chk("rstq load resp_valid", 32'(resp_valid), 32'd1);
    chk("rstq load resp_rdata", resp_rdata, 32'd0);

    // Randomized traffic against the reference model
    rst = 1'b1;
    drive_cycle(0, 0, 3'b000, 32'h0, 32'h0);
    rst = 1'b0;
    amem = pmem;
    have_req = 1'b0; stall_cnt = 0;
    cv = 1'b0; cwe = 1'b0; cc = 3'b000; ca = '0; cd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!have_req) begin
        if ($urandom_range(0, 3) == 0) begin
          cv = 1'b0;
        end else begin
          cv = 1'b1; have_req = 1'b1; stall_cnt = 0;
          cwe = 1'($urandom_range(0, 1));
          cc = 3'($urandom_range(0, 7));
          off = 32'($urandom_range(0, 15));
          if ($urandom_range(0, 1) == 1) off = off & ~32'd3;
          ca = 32'h8000_0100 + off;
          cd = $urandom;
        end
      end
      lg = m_legal(cc, ca);
      memload = 1'b0; stall = 1'b0; exp_data = '0;
      if (cv && lg && !cwe) begin
        memload = 1'b1;
        for (int k = q.size() - 1; k >= 0; k--) begin
          if ((q[k].addr >> 2) == (ca >> 2)) begin
            memload = 1'b0;
            stall = !((q[k].addr == ca) && (q[k].ctr[1:0] == cc[1:0]));
            break;
          end
        end
        exp_data = mread(1'b1, ca, cc);
      end
      drain_m = (q.size() > 0) && !memload;
      if (!lg)      exp_rdy = 1'b1;
      else if (cwe) exp_rdy = (q.size() < DEPTH) || drain_m;
      else          exp_rdy = !stall;

      drive_cycle(cv, cwe, cc, ca, cd);

      if (cv) chk("rnd req_ready", 32'(cap_ready), 32'(exp_rdy));
      chk("rnd mem_we", 32'(cap_we), 32'(drain_m));
      if (drain_m) begin
        chk("rnd drain mem_addr", cap_addr, q[0].addr);
        chk("rnd drain mem_ctr", 32'(cap_ctr), 32'(q[0].ctr));
        chk("rnd drain mem_wd", cap_wd, q[0].wdata);
        void'(q.pop_front());
      end
      if (memload) begin
        chk("rnd load mem_addr", cap_addr, ca);
        chk("rnd load mem_ctr", 32'(cap_ctr), 32'(cc));
      end
      acc = cv && exp_rdy;
      if (acc && lg && cwe) begin
        q.push_back('{addr: ca, ctr: cc, wdata: cd});
        mwrite(1'b1, ca, cc, cd);
      end
      chk("rnd resp_valid", 32'(resp_valid), 32'(acc && lg && !cwe));
      if (acc && lg && !cwe) chk("rnd resp_rdata", resp_rdata, exp_data);
      chk("rnd misalign_err", 32'(misalign_err), 32'(cv && !lg));
      chk("rnd sb_empty", 32'(sb_empty), 32'(q.size() == 0));

      if (acc || !cv) begin
        have_req = 1'b0;
      end else begin
        stall_cnt++;
        if (stall_cnt > 8) begin
          chk("rnd stall bound", 32'(stall_cnt), 32'd8);
          have_req = 1'b0;
        end
      end
    end

    // Let everything drain, then physical memory must match program order
    for (int i = 0; i < 20 && !sb_empty; i++) drive_cycle(0, 0, 3'b000, 32'h0, 32'h0);
    chk("final sb_empty", 32'(sb_empty), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("final mem byte %0d", i),
          32'(mread(1'b0, 32'h8000_0100 + 32'(i), 3'b100)),
          32'(mread(1'b1, 32'h8000_0100 + 32'(i), 3'b100)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
